det_job_scheduler: RTL and testbench

DET_JOB_SCHEDULER -- requirements
Module: det_job_scheduler

---
 rtl/det_job_scheduler.sv | 113 +++++++++++
 tb/tb_det_job_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/det_job_scheduler.sv
// Round-robin job scheduler feeding a shared 4-state Moore pattern detector.
// Each granted word is shifted MSB-first through the detector; hits are counted and reported.
module det_job_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CntW = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*WIDTH-1:0]   data_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [IdW-1:0]           doneId_o,
  output logic [CntW-1:0]          hitCount_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_e;
  typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_e;

  ctrl_e              state_q;
  det_e               det_q, det_d;
  logic [WIDTH-1:0]   sr_q;
  logic [CntW-1:0]    bitCnt_q, hitCnt_q, hitCnt_d;
  logic [IdW-1:0]     grant_q, lastGrant_q, grantIdx;
  logic               grantFound;
  logic [N_REQ-1:0]   ack_q;
  logic               done_q;
  logic [IdW-1:0]     doneId_q;
  logic [CntW-1:0]    hitCount_q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    grantIdx   = lastGrant_q;
    grantFound = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(lastGrant_q) + k) % N_REQ;
      if (!grantFound && req_i[idx]) begin
        grantFound = 1'b1;
        grantIdx   = IdW'(idx);
      end
    end
  end

  always_comb begin
    det_d = det_q;
    unique case (det_q)
      DET_A: det_d = sr_q[WIDTH-1] ? DET_C : DET_B;
      DET_B: det_d = sr_q[WIDTH-1] ? DET_D : DET_C;
      DET_C: det_d = sr_q[WIDTH-1] ? DET_D : DET_B;
      DET_D: det_d = sr_q[WIDTH-1] ? DET_A : DET_C;
    endcase
    hitCnt_d = hitCnt_q + ((det_d == DET_D) ? CntW'(1) : CntW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      det_q       <= DET_A;
      sr_q        <= '0;
      bitCnt_q    <= '0;
      hitCnt_q    <= '0;
      grant_q     <= '0;
      lastGrant_q <= IdW'(N_REQ - 1);
      ack_q       <= '0;
      done_q      <= 1'b0;
      doneId_q    <= '0;
      hitCount_q  <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            state_q     <= SHIFT;
            grant_q     <= grantIdx;
            lastGrant_q <= grantIdx;
            sr_q        <= data_i[grantIdx*WIDTH +: WIDTH];
            det_q       <= DET_A;
            bitCnt_q    <= '0;
            hitCnt_q    <= '0;
            ack_q       <= {{(N_REQ-1){1'b0}}, 1'b1} << grantIdx;
          end
        end
        SHIFT: begin
          det_q    <= det_d;
          sr_q     <= sr_q << 1;
          hitCnt_q <= hitCnt_d;
          bitCnt_q <= bitCnt_q + CntW'(1);
          // Result registers are loaded as the last bit is consumed so done and its data line up.
          if (bitCnt_q == CntW'(WIDTH - 1)) begin
            state_q    <= REPORT;
            done_q     <= 1'b1;
            doneId_q   <= grant_q;
            hitCount_q <= hitCnt_d;
          end
        end
        REPORT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign doneId_o   = doneId_q;
  assign hitCount_o = hitCount_q;

endmodule

// File: tb/tb_det_job_scheduler.sv
// Bench for det_job_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a job-level reference model of grants and detector hits.
module tb_det_job_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic                   done;
  logic [1:0]             doneId;
  logic [3:0]             hitCount;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state
  bit               mActive;
  int               mStep;
  int               mLast;
  int               mGrant;
  int               mHits;
  logic [N_REQ-1:0] expAck;
  logic             expBusy;
  logic             expDone;
  int               expDoneId;
  int               expHit;

  det_job_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .data_i    (data),
    .ack_o     (ack),
    .busy_o    (busy),
    .done_o    (done),
    .doneId_o  (doneId),
    .hitCount_o(hitCount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Detector transition table with states A=0, B=1, C=2, D=3; a hit is every arrival in D.
  function automatic int refHits(input logic [WIDTH-1:0] w);
    int st = 0;
    int hits = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      case (st)
        0:       st = w[b] ? 2 : 1;
        1:       st = w[b] ? 3 : 2;
        2:       st = w[b] ? 3 : 1;
        default: st = w[b] ? 0 : 2;
      endcase
      if (st == 3) hits++;
    end
    return hits;
  endfunction

  // Predicts what the outputs look like in the cycle following the coming clock edge.
  task automatic modelEdge(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ*WIDTH-1:0] d);
    if (r) begin
      mActive   = 0;
      mStep     = 0;
      mLast     = N_REQ - 1;
      expDoneId = 0;
      expHit    = 0;
    end else if (!mActive) begin
      if (rq != '0) begin
        for (int off = 1; off <= N_REQ; off++) begin
          int idx = (mLast + off) % N_REQ;
          if (rq[idx]) begin
            mGrant = idx;
            break;
          end
        end
        mHits   = refHits(d[mGrant*WIDTH +: WIDTH]);
        mLast   = mGrant;
        mActive = 1;
        mStep   = 1;
      end
    end else begin
      mStep++;
      if (mStep == WIDTH + 2) begin
        mActive = 0;
        mStep   = 0;
      end
    end
    expBusy = mActive;
    expAck  = (mActive && mStep == 1) ? N_REQ'(1 << mGrant) : '0;
    expDone = mActive && (mStep == WIDTH + 1);
    if (expDone) begin
      expDoneId = mGrant;
      expHit    = mHits;
    end
  endtask

  // Drives one cycle of inputs, lets the edge pass, then compares against the model.
  task automatic applyStimulus(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ*WIDTH-1:0] d);
    rst  = r;
    req  = rq;
    data = d;
    modelEdge(r, rq, d);
    @(negedge clk);
    cycle++;
    checkOutput("ack",      32'(ack),      32'(expAck));
    checkOutput("busy",     32'(busy),     32'(expBusy));
    checkOutput("done",     32'(done),     32'(expDone));
    checkOutput("doneId",   32'(doneId),   32'(expDoneId));
    checkOutput("hitCount", 32'(hitCount), 32'(expHit));
  endtask

  logic [N_REQ*WIDTH-1:0] dataDrv;
  logic [N_REQ-1:0]       reqDrv;
  logic                   rstDrv;
  int                     ack3;
  int                     dones;

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    @(negedge clk);

    // Reset state, then a single 8'hFF job from requester 0
    applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b0, '0, '0);
    dataDrv = '0;
    dataDrv[7:0] = 8'hFF;
    applyStimulus(1'b0, 4'b0001, dataDrv);
    checkOutput("ack_ff", 32'(ack), 32'h1);
    repeat (WIDTH) applyStimulus(1'b0, '0, '0);
    checkOutput("done_ff",  32'(done),     32'h1);
    checkOutput("id_ff",    32'(doneId),   32'h0);
    checkOutput("hits_ff",  32'(hitCount), 32'h3);
    applyStimulus(1'b0, '0, '0);

    // Requester 1 with all-zero and 8'h40 words
    dataDrv = '0;
    dataDrv[15:8] = 8'h00;
    applyStimulus(1'b0, 4'b0010, dataDrv);
    repeat (WIDTH) applyStimulus(1'b0, '0, '0);
    checkOutput("id_00",   32'(doneId),   32'h1);
    checkOutput("hits_00", 32'(hitCount), 32'h0);
    applyStimulus(1'b0, '0, '0);
    dataDrv[15:8] = 8'h40;
    applyStimulus(1'b0, 4'b0010, dataDrv);
    repeat (WIDTH) applyStimulus(1'b0, '0, '0);
    checkOutput("hits_40", 32'(hitCount), 32'h1);
    applyStimulus(1'b0, '0, '0);

    // All requesters held: grants rotate 0,1,2,3,0 every WIDTH+2 cycles
    applyStimulus(1'b1, '0, '0);
    dataDrv = {$urandom, $urandom};
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 4'b1111, dataDrv);
      checkOutput($sformatf("rr_ack%0d", j), 32'(ack), 32'(1 << (j % N_REQ)));
      repeat (WIDTH + 1) applyStimulus(1'b0, 4'b1111, dataDrv);
    end

    // Reset in the 4th shift cycle aborts the job; next job runs normally
    applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b0, 4'b0001, {$urandom, $urandom});
    repeat (3) applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, '0, '0);
    checkOutput("abort_busy", 32'(busy),     32'h0);
    checkOutput("abort_hits", 32'(hitCount), 32'h0);
    repeat (WIDTH + 2) applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b0, 4'b0100, {$urandom, $urandom});
    checkOutput("post_ack", 32'(ack), 32'h4);
    repeat (WIDTH) applyStimulus(1'b0, '0, '0);
    checkOutput("post_done", 32'(done),   32'h1);
    checkOutput("post_id",   32'(doneId), 32'h2);
    applyStimulus(1'b0, '0, '0);

    // A one-cycle request pulse while busy is never served
    ack3  = 0;
    dones = 0;
    applyStimulus(1'b0, 4'b0001, {$urandom, $urandom});
    applyStimulus(1'b0, 4'b1000, {$urandom, $urandom});
    repeat (WIDTH + 3) begin
      applyStimulus(1'b0, '0, '0);
      if (ack[3]) ack3++;
      if (done) dones++;
    end
    checkOutput("pulse_ack3",  32'(ack3),  32'h0);
    checkOutput("pulse_dones", 32'(dones), 32'h1);

    // Random traffic: requests held until acked, occasional withdrawals and resets
    applyStimulus(1'b1, '0, '0);
    reqDrv  = '0;
    dataDrv = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (expAck[i]) begin
          reqDrv[i] = 1'b0;
        end else if (!reqDrv[i] && $urandom_range(0, 3) == 0) begin
          reqDrv[i] = 1'b1;
          dataDrv[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (reqDrv[i] && $urandom_range(0, 19) == 0) begin
          reqDrv[i] = 1'b0;
        end
      end
      rstDrv = ($urandom_range(0, 149) == 0);
      applyStimulus(rstDrv, reqDrv, dataDrv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
